// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the multicycle CPU's unified memory port (CPU vs DMA loader).
// Optional wait-for-ready timeout with sticky bus_err: define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DMA = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state;
  logic   last_grant;  // 1 = DMA was granted last
  logic   grant_dma;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;
  logic        err_flag;
  assign bus_err = err_flag;
`else
  localparam bit TIMEOUT_OK = (TIMEOUT >= 1) && (TIMEOUT <= 65535);
  // Structurally zero; the expression only keeps TIMEOUT referenced.
  assign bus_err = 1'b0 & TIMEOUT_OK;
`endif

  // On a tie the requester that was not granted last wins.
  assign grant_dma = dma_req & (~cpu_req | ~last_grant);
  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      err_flag   <= 1'b0;
`endif
    end else begin
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_dma ? dma_we    : cpu_we;
            mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            state     <= grant_dma ? BUSY_DMA  : BUSY_CPU;
`ifdef ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        BUSY_CPU, BUSY_DMA: begin
          if (mem_ready) begin
            if (!mem_we) rdata <= mem_rdata;
            mem_req  <= 1'b0;
            cpu_done <= (state == BUSY_CPU);
            dma_done <= (state == BUSY_DMA);
            state    <= DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == LIMIT) begin
            mem_req  <= 1'b0;
            err_flag <= 1'b1;
            rdata    <= '0;
            cpu_done <= (state == BUSY_CPU);
            dma_done <= (state == BUSY_DMA);
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          // The done pulse in flight identifies who just finished.
          last_grant <= dma_done;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port of the multicycle CPU between two requesters: the CPU control path (instruction fetch and data access, selected by IorD upstream) and a DMA/debug loader port. Runs a registered grant FSM with round-robin priority, and drives one memory transaction at a time against a variable-latency memory. It tells the CPU control FSM when to freeze and when read data is valid.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for mem_ready (only with ARB_TIMEOUT_EN); 1..65535
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_req / dma_req  in  1  request, level, held until matching done
- cpu_we / dma_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / dma_addr  in  ADDR_W  address; stable while req high
- cpu_wdata / dma_wdata  in  DATA_W  write data; stable while req high
- cpu_stall  out  1  CPU must hold its state register this cycle
- cpu_done / dma_done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  registered read data, valid with done, held until next read completes
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ready  in  1  memory accepts/completes the access this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready
- bus_err  out  1  sticky timeout flag (constant 0 without ARB_TIMEOUT_EN)

## Operation
- States: IDLE, BUSY_CPU, BUSY_DMA, DONE.
- IDLE: if any req, grant per round-robin. Latch we/addr/wdata into mem_* registers, set mem_req=1, go BUSY_x.
- Round-robin: last_grant bit. On a tie, the requester not granted last wins. After reset last_grant=DMA, so the CPU wins the first tie.
- BUSY_x: hold mem_req and mem_* stable. On mem_ready: for reads, capture mem_rdata into rdata; drop mem_req; go DONE.
- DONE: pulse x_done=1 for exactly this cycle; update last_grant=x; go IDLE. The requester drops or changes req on the following cycle. A req still high in IDLE is a new transaction.
- cpu_stall = cpu_req & ~cpu_done (combinational). The CPU stalls while waiting for a grant and while its access is in flight, and advances in the cycle cpu_done is high.
- Writes do not modify rdata.
- Requests deasserted while in BUSY_x are ignored: the transaction completes and done still pulses.

## Timing
- Reset (reset_n=0 at edge): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, cpu_done=0, dma_done=0, bus_err=0, last_grant=DMA.
- Reset mid-transaction aborts it: mem_req=0 after that edge, and no done pulse.
- Latency: req seen in IDLE at edge N gives mem_req=1 from N+1. mem_ready at edge M gives done high in cycle M+1.
- Minimum transaction is 3 cycles (IDLE, BUSY, DONE) with mem_ready already high in the first BUSY cycle.
- Back-to-back with both requesting continuously, grants alternate CPU, DMA, CPU, and so on.
- mem_ready outside BUSY is ignored.

## Configuration
- ARB_TIMEOUT_EN defined: a 16-bit counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT: drop mem_req, set bus_err=1 (sticky until reset), force rdata=0, go DONE. The done pulse still fires, so the requester is not left hung.
- ARB_TIMEOUT_EN undefined: no counter. BUSY waits indefinitely and bus_err is tied to 0.

## Test plan
- Reset then CPU read of 0x40, memory returns 0xDEADBEEF with mem_ready 2 cycles after mem_req -> mem_addr=0x40, cpu_done pulses once, rdata=0xDEADBEEF, cpu_stall low in the done cycle.
- Both req rise in the same cycle, held -> grant order CPU, DMA, CPU, DMA; never two done pulses in one cycle.
- DMA write 0x1234 to 0x80 while the CPU is idle -> mem_we=1, mem_wdata=0x1234, dma_done pulses, rdata unchanged.
- reset_n low during BUSY_DMA -> next cycle mem_req=0, no dma_done, state IDLE, bus_err=0.
- mem_ready held high, continuous CPU reads -> one transaction every 3 cycles, mem_req low during each DONE cycle.
- With ARB_TIMEOUT_EN and TIMEOUT=4, mem_ready never asserted -> mem_req drops after 4 BUSY cycles, bus_err=1, done pulses, rdata=0. Without the macro, mem_req stays high indefinitely.
